// File: rtl/bridge_engine.sv
// -----------------------------------------------------------------------------
// bridge_engine
//   Central sequencer of the AXI2APB bridge. Arbitrates between pending read
//   and write bursts, then drives the APB master one beat at a time. Each beat
//   waits for data-path availability. After the last beat it returns an
//   aggregated OKAY/SLVERR response to the side that was granted.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   rd_req_valid/len, rd_req_ack  read burst request / one-cycle grant pulse
//   wr_req_valid/len, wr_req_ack  write burst request / one-cycle grant pulse
//   wr_fifo_empty, rd_fifo_full   data FIFO availability for the next beat
//   apb_start                   one-cycle pulse launching one APB transfer
//   apb_write, apb_beat_idx     direction and 0-based beat index of the burst
//   apb_beat_done, apb_beat_err beat completion and its PSLVERR
//   rd_resp_valid/err/ready     read burst response handshake
//   wr_resp_valid/err/ready     write burst response handshake
//   busy                        sequencer is not idle
// -----------------------------------------------------------------------------
module bridge_engine #(
    parameter int LEN_W = 8,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req_valid,
    input  logic [LEN_W-1:0] rd_req_len,
    output logic             rd_req_ack,
    input  logic             wr_req_valid,
    input  logic [LEN_W-1:0] wr_req_len,
    output logic             wr_req_ack,
    input  logic             wr_fifo_empty,
    input  logic             rd_fifo_full,
    output logic             apb_start,
    output logic             apb_write,
    output logic [LEN_W-1:0] apb_beat_idx,
    input  logic             apb_beat_done,
    input  logic             apb_beat_err,
    output logic             rd_resp_valid,
    output logic             rd_resp_err,
    input  logic             rd_resp_ready,
    output logic             wr_resp_valid,
    output logic             wr_resp_err,
    input  logic             wr_resp_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;      // 1 = write burst
    logic [LEN_W-1:0] len_q, len_d;      // beats-1 of the granted burst
    logic [LEN_W-1:0] beat_q, beat_d;    // index of the beat in flight
    logic             err_q, err_d;      // sticky SLVERR over the burst
    logic             first_q, first_d;  // first ISSUE cycle of the burst
    logic             prio_q, prio_d;    // 1 = write wins a tie (FAIR only)

    logic             blocked;
    logic             grant_wr;
    logic             resp_ready;

    // A beat may only start when its FIFO can source/sink the data.
    assign blocked    = dir_q ? wr_fifo_empty : rd_fifo_full;
    assign resp_ready = dir_q ? wr_resp_ready : rd_resp_ready;

    always_comb begin
        if (rd_req_valid && wr_req_valid) begin
            grant_wr = FAIR ? prio_q : 1'b0;
        end else begin
            grant_wr = wr_req_valid;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        first_d = first_q;
        prio_d  = prio_q;

        case (state_q)
            S_IDLE: begin
                if (rd_req_valid || wr_req_valid) begin
                    dir_d   = grant_wr;
                    len_d   = grant_wr ? wr_req_len : rd_req_len;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                first_d = 1'b0;
                if (!blocked) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (apb_beat_done) begin
                    err_d = err_q | apb_beat_err;
                    // Compare before incrementing so len = all-ones never wraps.
                    if (beat_q == len_q) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    if (FAIR) begin
                        prio_d = ~dir_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            first_q <= first_d;
            prio_q  <= prio_d;
        end
    end

    // All outputs decode from registered state only, so reset clears them at once.
    assign busy          = (state_q != S_IDLE);
    assign rd_req_ack    = (state_q == S_ISSUE) && first_q && !dir_q;
    assign wr_req_ack    = (state_q == S_ISSUE) && first_q && dir_q;
    assign apb_start     = (state_q == S_START);
    assign apb_write     = busy && dir_q;
    assign apb_beat_idx  = busy ? beat_q : '0;
    assign rd_resp_valid = (state_q == S_RESP) && !dir_q;
    assign rd_resp_err   = (state_q == S_RESP) && !dir_q && err_q;
    assign wr_resp_valid = (state_q == S_RESP) && dir_q;
    assign wr_resp_err   = (state_q == S_RESP) && dir_q && err_q;

endmodule

// File: doc/bridge_engine.md
Name: bridge_engine

Overview:
Central sequencer of the AXI2APB bridge. It arbitrates between burst requests captured by the AXI read side (axi_reader) and the AXI write side (axi_writer), then drives the APB master one beat at a time. Each beat is gated on read/write FIFO availability. After the last beat it returns an aggregated OKAY/SLVERR response to the granted AXI side. Sits between the AXI slave front-ends, the data FIFOs and the APB master.

Parameters:
LEN_W, 8, width of burst length field (AXI LEN, beats-1)
FAIR, 1, 1 = round-robin read/write arbitration; 0 = fixed read priority

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rd_req_valid  input  1  read burst pending; held until rd_req_ack
rd_req_len  input  LEN_W  read beats-1, stable while rd_req_valid
rd_req_ack  output  1  one-cycle pulse: read burst granted
wr_req_valid  input  1  write burst pending; held until wr_req_ack
wr_req_len  input  LEN_W  write beats-1, stable while wr_req_valid
wr_req_ack  output  1  one-cycle pulse: write burst granted
wr_fifo_empty  input  1  write-data FIFO has no beat for APB
rd_fifo_full  input  1  read-data FIFO cannot accept an APB beat
apb_start  output  1  one-cycle pulse: APB master begins one transfer
apb_write  output  1  direction of current burst (1 = write), valid while busy
apb_beat_idx  output  LEN_W  index of current beat, 0-based
apb_beat_done  input  1  APB master finished a beat (PREADY phase done)
apb_beat_err  input  1  PSLVERR of that beat, qualified by apb_beat_done
rd_resp_valid  output  1  read burst complete, response pending
rd_resp_err  output  1  1 = SLVERR, valid with rd_resp_valid
rd_resp_ready  input  1  axi_reader accepted response
wr_resp_valid  output  1  write burst complete, B response pending
wr_resp_err  output  1  1 = SLVERR, valid with wr_resp_valid
wr_resp_ready  input  1  axi_writer accepted response
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; beat counter 0; sticky error 0; priority pointer = read.
- States: IDLE, ISSUE, START, WAIT, RESP.
- IDLE, arbitration:
  - Only read valid -> read; only write valid -> write.
  - Both valid: FAIR=1 -> side indicated by priority pointer; FAIR=0 -> read.
  - On grant: latch direction and len; clear beat counter and sticky error; go to ISSUE.
- ISSUE:
  - {rd,wr}_req_ack = 1 on the first ISSUE cycle of a burst only.
  - Stays in ISSUE while the data path is blocked: write burst with wr_fifo_empty=1, or read burst with rd_fifo_full=1.
  - Otherwise goes to START.
- START: apb_start = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - apb_beat_done is sampled only here; it is ignored in all other states.
  - On done: sticky_err |= apb_beat_err.
  - If beat == len -> RESP; else beat += 1 -> ISSUE (no ack).
  - Minimum 3 cycles per beat.
- RESP:
  - {rd,wr}_resp_valid = 1 and {rd,wr}_resp_err = sticky_err, held until the matching ready is seen.
  - On ready: go to IDLE; if FAIR=1, priority pointer points to the side not just served.
- Error handling: an error beat does not abort the burst; all len+1 beats are issued (AXI burst must complete).
- Arithmetic: len=255 produces 256 beats. The beat counter never wraps inside a burst (compare before increment).
- Requests: those arriving outside IDLE wait; request inputs are ignored until IDLE.
- apb_write, apb_beat_idx: hold their values from grant through RESP; forced to 0 in IDLE.
- Mid-operation reset: immediate return to IDLE; no resp or ack pulse is emitted afterwards; the in-flight burst is lost.

Test Plan:
- Read, len=0, FIFO not full, apb_beat_done 2 cycles after apb_start, err=0 -> rd_req_ack 1 pulse; apb_start 1 pulse with apb_write=0, idx=0; rd_resp_valid=1, err=0 until rd_resp_ready; busy 0 afterwards.
- Write, len=3, wr_fifo_empty=1 for 5 cycles before beat 2 -> 4 apb_start pulses with idx 0..3 and apb_write=1; no apb_start while empty; wr_resp_err=0.
- rd/wr valid in the same cycle, FAIR=1, both len=0, repeated 4 times -> grants R,W,R,W; with FAIR=0 -> all reads served before any write.
- Write len=3, apb_beat_err=1 on beat 1 only -> 4 beats still issued; wr_resp_err=1; next burst with no errors reports err=0.
- Read len=255 -> exactly 256 apb_start pulses, idx 0..255, single rd_resp.
- rst asserted during WAIT of beat 2 of a len=5 write -> all outputs 0 asynchronously; no wr_resp_valid; a following read is granted first.
